// File: rtl/aes_decrypt_iterative_pkg.sv
// Shared AES-128 inverse-cipher types, inverse S-box and round helper functions.
package aes_decrypt_iterative_pkg;

  localparam int unsigned NumRounds = 10;
  localparam int unsigned BlockW    = 128;
  localparam int unsigned SchedW    = BlockW * (NumRounds + 1);

  localparam logic [3:0] FirstInvRound = 4'(NumRounds - 1);
  localparam logic [3:0] LastKeyIdx    = 4'(NumRounds);

  typedef logic [0:BlockW-1] block_t;
  typedef logic [0:SchedW-1] sched_t;
  typedef logic [0:7]        id_t;

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  // Byte b of the table sits at bits [8b:8b+7].
  localparam logic [0:2047] InvSboxTbl = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] fn_inv_sbox(logic [7:0] b);
    return InvSboxTbl[{b, 3'b000} +: 8];
  endfunction

  function automatic block_t fn_inv_sub_bytes(block_t s);
    block_t o;
    for (int n = 0; n < 16; n++) begin
      o[8*n +: 8] = fn_inv_sbox(s[8*n +: 8]);
    end
    return o;
  endfunction

  // Byte (row r, column c) lives at index 4c+r; row r rotates right by r.
  function automatic block_t fn_inv_shift_rows(block_t s);
    block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = s[8*(4*((c - r + 4) % 4) + r) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [7:0] fn_xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] fn_gf_mul(logic [7:0] b, logic [3:0] c);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = b;
    for (int i = 0; i < 4; i++) begin
      if (c[i]) acc ^= p;
      p = fn_xtime(p);
    end
    return acc;
  endfunction

  function automatic block_t fn_inv_mix_columns(block_t s);
    block_t     o;
    logic [7:0] a [4];
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = s[8*(4*c+r) +: 8];
      for (int r = 0; r < 4; r++) begin
        o[8*(4*c+r) +: 8] = fn_gf_mul(a[r], 4'he) ^ fn_gf_mul(a[(r+1)%4], 4'hb) ^
                            fn_gf_mul(a[(r+2)%4], 4'hd) ^ fn_gf_mul(a[(r+3)%4], 4'h9);
      end
    end
    return o;
  endfunction

  function automatic block_t fn_round_key(sched_t sched, logic [3:0] k);
    return sched[{k, 7'b0000000} +: BlockW];
  endfunction

endpackage

// File: rtl/aes_decrypt_iterative_if.sv
// Handshake and data bundle between a block source/sink and the iterative decryptor.
interface aes_decrypt_iterative_if;
  import aes_decrypt_iterative_pkg::*;

  logic   i_valid;
  logic   o_ready;
  block_t i_cipher_text;
  sched_t i_key_schedule;
  id_t    i_block_id;
  logic   o_valid;
  logic   i_ready;
  block_t o_plain_text;
  id_t    o_block_id;

  modport slave (
    input  i_valid, i_cipher_text, i_key_schedule, i_block_id, i_ready,
    output o_ready, o_valid, o_plain_text, o_block_id
  );

  modport master (
    output i_valid, i_cipher_text, i_key_schedule, i_block_id, i_ready,
    input  o_ready, o_valid, o_plain_text, o_block_id
  );
endinterface

// File: rtl/aes_decrypt_iterative_inv_round.sv
// One combinational AES inverse round; the final round skips InvMixColumns.
module aes_decrypt_iterative_inv_round
  import aes_decrypt_iterative_pkg::*;
(
  input  block_t blk,
  input  block_t round_key,
  input  logic   is_final,
  output block_t next_blk
);

  block_t keyed;

  always_comb begin
    keyed    = fn_inv_sub_bytes(fn_inv_shift_rows(blk)) ^ round_key;
    next_blk = is_final ? keyed : fn_inv_mix_columns(keyed);
  end

endmodule

// File: rtl/aes_decrypt_iterative.sv
// Iterative AES-128 decryptor: one inverse round per clock, valid/ready on both sides.
module aes_decrypt_iterative
  import aes_decrypt_iterative_pkg::*;
(
  input logic                    clk,
  input logic                    rst,
  aes_decrypt_iterative_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  block_t     blk_q, blk_d;
  id_t        id_q, id_d;
  sched_t     sched_q;
  block_t     round_out;
  logic       accept;

  assign bus.o_ready      = (state_q == StIdle) && !rst;
  assign bus.o_valid      = (state_q == StDone);
  assign bus.o_plain_text = blk_q;
  assign bus.o_block_id   = id_q;

  assign accept = bus.i_valid && bus.o_ready;

  aes_decrypt_iterative_inv_round u_inv_round (
    .blk       (blk_q),
    .round_key (fn_round_key(sched_q, round_q)),
    .is_final  (round_q == 4'd0),
    .next_blk  (round_out)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    blk_d   = blk_q;
    id_d    = id_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Initial AddRoundKey uses the live schedule; later rounds use the latched copy.
          blk_d   = bus.i_cipher_text ^ fn_round_key(bus.i_key_schedule, LastKeyIdx);
          id_d    = bus.i_block_id;
          round_d = FirstInvRound;
          state_d = StRound;
        end
      end
      StRound: begin
        blk_d = round_out;
        if (round_q == 4'd0) begin
          state_d = StDone;
        end else begin
          round_d = round_q - 4'd1;
        end
      end
      StDone: begin
        if (bus.i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
      blk_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      blk_q   <= blk_d;
      id_q    <= id_d;
    end
  end

  // Schedule storage carries no reset; it is always written before first use.
  always_ff @(posedge clk) begin
    if (accept) sched_q <= bus.i_key_schedule;
  end

endmodule
